// File: rtl/sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// sub_bytes_seq
//   Iterative AES SubBytes engine. A 128-bit state is accepted over a
//   valid/ready handshake, substituted LANES bytes per cycle through the
//   forward AES S-box, and presented on a second valid/ready handshake.
//
//   Ports
//     clk        : sole clock, rising edge
//     rst_n      : asynchronous active-low reset
//     in_valid   : state_in is valid
//     in_ready   : block accepts state_in this cycle
//     state_in   : AES state, byte 0 in [127:120], byte 15 in [7:0]
//     out_valid  : state_out holds a completed SubBytes result
//     out_ready  : consumer accepts state_out this cycle
//     state_out  : substituted state, same byte order as state_in
//     busy       : high while substitution is in progress
// -----------------------------------------------------------------------------

// Forward AES S-box as a single combinational lookup.
module aes_sbox (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  // Entry 0x00 occupies the top byte, entry 0xFF the bottom byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte lookup: entry b starts 8*b bits below the MSB.
  always_comb begin
    byte_o = SBOX_TABLE[11'd2047 - {byte_i, 3'd0} -: 8];
  end

endmodule

module sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  localparam int GROUPS = 16 / LANES;
  // LANES=16 needs no counting, but a zero-width counter is not legal.
  localparam int CW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(GROUPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic [127:0]        work_q;
  logic                out_valid_q;
  logic                busy_q;

  logic [15:0][7:0]      work_bytes_s;
  logic [15:0][7:0]      work_d;
  logic [LANES-1:0][3:0] lane_idx_s;
  logic [LANES-1:0][7:0] lane_sub_s;

  assign work_bytes_s = work_q;

  // Byte numbering is MSB-first, so byte i lives in packed element 15-i.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    // Index of the byte handled by this lane in the current group.
    always_comb begin
      lane_idx_s[l] = 4'(int'(cnt_q) * LANES + l);
    end

    aes_sbox u_sbox (
      .byte_i (work_bytes_s[4'd15 - lane_idx_s[l]]),
      .byte_o (lane_sub_s[l])
    );
  end

  // Working register with the current byte group replaced by its S-box images.
  always_comb begin
    work_d = work_bytes_s;
    for (int l = 0; l < LANES; l++) begin
      work_d[4'd15 - lane_idx_s[l]] = lane_sub_s[l];
    end
  end

  // in_ready is combinational so a DONE block can hand off and reload on one edge.
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = out_valid_q;
  assign state_out = work_q;
  assign busy      = busy_q;

  // Control FSM with registered status outputs and the working datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      work_q      <= 128'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q  <= state_in;
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          work_q <= work_d;
          if (cnt_q == CNT_LAST) begin
            cnt_q       <= {CW{1'b0}};
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              // Output handoff and new load on the same edge: no IDLE bubble.
              work_q  <= state_in;
              cnt_q   <= {CW{1'b0}};
              busy_q  <= 1'b1;
              state_q <= RUN;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= {CW{1'b0}};
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_bytes_seq.sv
module tb_sub_bytes_seq;

  logic         clk;
  logic         rst_n;
  logic [127:0] state_in;
  logic         in_valid1, in_valid4, in_valid16;
  logic         out_ready1, out_ready4, out_ready16;
  logic         in_ready1, in_ready4, in_ready16;
  logic         out_valid1, out_valid4, out_valid16;
  logic         busy1, busy4, busy16;
  logic [127:0] state_out1, state_out4, state_out16;

  int tests_run;
  int tests_failed;
  logic [7:0] sbox_tab [256];

  sub_bytes_seq #(.LANES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .state_in(state_in), .out_valid(out_valid1), .out_ready(out_ready1),
    .state_out(state_out1), .busy(busy1)
  );
  sub_bytes_seq #(.LANES(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .state_in(state_in), .out_valid(out_valid4), .out_ready(out_ready4),
    .state_out(state_out4), .busy(busy4)
  );
  sub_bytes_seq #(.LANES(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .state_in(state_in), .out_valid(out_valid16), .out_ready(out_ready16),
    .state_out(state_out16), .busy(busy16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // GF(2^8) multiply, AES polynomial.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    logic       hi;
    p = 8'd0; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      hi = aa[7];
      aa = aa << 1;
      if (hi) aa = aa ^ 8'h1b;
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] x;
    x = 8'd0;
    if (a != 8'd0) begin
      for (int c = 1; c < 256; c++) begin
        if (gmul(a, 8'(c)) == 8'd1) x = 8'(c);
      end
    end
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_state(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox_tab[s[127-8*i -: 8]];
    return r;
  endfunction

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] ZERO_OUT = 128'h63636363636363636363636363636363;

  initial begin
    logic [127:0] vecs [3];
    logic [127:0] held;
    logic         take_in, take_out;
    int           sent, recv, t, last_t, k;

    tests_run = 0;
    tests_failed = 0;
    for (int b = 0; b < 256; b++) sbox_tab[b] = sbox_calc(8'(b));

    rst_n = 1'b1;
    state_in = 128'd0;
    in_valid1 = 1'b0; in_valid4 = 1'b0; in_valid16 = 1'b0;
    out_ready1 = 1'b0; out_ready4 = 1'b0; out_ready16 = 1'b0;

    // Asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_in_ready", 128'(in_ready4), 128'd1);
    check_eq("rst_out_valid", 128'(out_valid4), 128'd0);
    check_eq("rst_busy", 128'(busy4), 128'd0);
    check_eq("rst_state_out", state_out4, 128'd0);
    step();
    step();

    // Zero state, transfer on the first edge after release
    rst_n = 1'b1;
    in_valid4 = 1'b1;
    state_in = 128'd0;
    step();
    in_valid4 = 1'b0;
    check_eq("zero_busy_start", 128'(busy4), 128'd1);
    check_eq("zero_in_ready_run", 128'(in_ready4), 128'd0);
    for (int c = 1; c < 4; c++) begin
      step();
      check_eq("zero_no_valid_yet", 128'(out_valid4), 128'd0);
      check_eq("zero_busy_run", 128'(busy4), 128'd1);
    end
    step();
    check_eq("zero_out_valid", 128'(out_valid4), 128'd1);
    check_eq("zero_busy_done", 128'(busy4), 128'd0);
    check_eq("zero_state_out", state_out4, ZERO_OUT);

    // Backpressure: 10 stalled cycles, new input offered but must be refused
    in_valid4 = 1'b1;
    state_in = FIPS_IN;
    for (int c = 0; c < 10; c++) begin
      check_eq("bp_in_ready", 128'(in_ready4), 128'd0);
      step();
      check_eq("bp_out_valid", 128'(out_valid4), 128'd1);
      check_eq("bp_state_out", state_out4, ZERO_OUT);
    end
    in_valid4 = 1'b0;
    out_ready4 = 1'b1;
    #1;
    check_eq("bp_in_ready_release", 128'(in_ready4), 128'd1);
    step();
    out_ready4 = 1'b0;
    check_eq("bp_one_xfer", 128'(out_valid4), 128'd0);
    check_eq("bp_idle_ready", 128'(in_ready4), 128'd1);
    step();
    check_eq("bp_stays_low", 128'(out_valid4), 128'd0);

    // FIPS-197 vector on all three lane widths: latencies 16, 4, 1
    out_ready1 = 1'b1; out_ready4 = 1'b1; out_ready16 = 1'b1;
    in_valid1 = 1'b1; in_valid4 = 1'b1; in_valid16 = 1'b1;
    state_in = FIPS_IN;
    step();
    in_valid1 = 1'b0; in_valid4 = 1'b0; in_valid16 = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      step();
      check_eq("fips_l1_valid", 128'(out_valid1), 128'(c == 16));
      check_eq("fips_l4_valid", 128'(out_valid4), 128'(c == 4));
      check_eq("fips_l16_valid", 128'(out_valid16), 128'(c == 1));
      if (c == 16) check_eq("fips_l1_data", state_out1, FIPS_OUT);
      if (c == 4)  check_eq("fips_l4_data", state_out4, FIPS_OUT);
      if (c == 1)  check_eq("fips_l16_data", state_out16, FIPS_OUT);
    end
    step();

    // Back-to-back traffic on LANES=4
    vecs[0] = FIPS_IN;
    vecs[1] = 128'h00112233445566778899aabbccddeeff;
    vecs[2] = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    sent = 0; recv = 0; t = 0; last_t = -1;
    state_in = vecs[0];
    in_valid4 = 1'b1;
    out_ready4 = 1'b1;
    while (recv < 3 && t < 60) begin
      take_in  = in_valid4 && in_ready4;
      take_out = out_valid4 && out_ready4;
      if (sent > 0) check_eq("b2b_no_idle", 128'(busy4 || out_valid4), 128'd1);
      if (take_out) begin
        check_eq("b2b_data", state_out4, sub_state(vecs[recv]));
        if (recv > 0) check_eq("b2b_gap", 128'(t - last_t), 128'd5);
        last_t = t;
        recv++;
      end
      step();
      t++;
      if (take_in) begin
        sent++;
        if (sent < 3) state_in = vecs[sent];
        else in_valid4 = 1'b0;
      end
    end
    check_eq("b2b_count", 128'(recv), 128'd3);
    in_valid4 = 1'b0;
    step();

    // Reset asserted mid-RUN at cnt=2
    state_in = vecs[1];
    in_valid4 = 1'b1;
    out_ready4 = 1'b0;
    step();
    in_valid4 = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 128'(busy4), 128'd0);
    check_eq("mid_rst_out_valid", 128'(out_valid4), 128'd0);
    check_eq("mid_rst_state_out", state_out4, 128'd0);
    check_eq("mid_rst_in_ready", 128'(in_ready4), 128'd1);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      check_eq("post_rst_no_valid", 128'(out_valid4 || busy4), 128'd0);
    end

    // Exhaustive S-box check through LANES=4
    out_ready4 = 1'b1;
    for (int b = 0; b < 256; b++) begin
      state_in = {16{8'(b)}};
      in_valid4 = 1'b1;
      step();
      in_valid4 = 1'b0;
      k = 0;
      while (!out_valid4 && k < 8) begin
        step();
        k++;
      end
      if (!out_valid4) begin
        check_eq("sbox_timeout", 128'(out_valid4), 128'd1);
      end else begin
        held = {16{sbox_tab[b]}};
        check_eq("sbox_all", state_out4, held);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sub_bytes_seq.md
SUB_BYTES_SEQ -- requirements
Module: sub_bytes_seq

Interface
REQ-001 The block SHALL have parameter LANES, default 4, giving the number of bytes substituted per cycle; legal values are 1, 2, 4, 8 and 16.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  state_in is valid.
REQ-005 in_ready  output  1  block accepts state_in this cycle.
REQ-006 state_in  input  128  AES state; byte 0 is [127:120], byte 15 is [7:0].
REQ-007 out_valid  output  1  state_out holds a completed SubBytes result.
REQ-008 out_ready  input  1  consumer accepts state_out this cycle.
REQ-009 state_out  output  128  substituted state, in the same byte order as state_in.
REQ-010 busy  output  1  high while in RUN.

Function
REQ-011 Each byte SHALL be mapped through the FIPS-197 forward AES S-box (for example S(00)=63, S(01)=7C, S(53)=ED, S(FF)=16); the mapping SHALL be built as LANES identical combinational lookup instances.
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 A transfer into the block SHALL occur on any rising edge where in_valid and in_ready are both high.
REQ-014 An output transfer SHALL occur on any rising edge where out_valid and out_ready are both high.
REQ-015 in_ready SHALL equal (state==IDLE) OR (state==DONE AND out_ready); it SHALL be low in RUN.
REQ-016 On an input transfer, the block SHALL load state_in into a 128-bit working register, clear the byte-group counter cnt, and enter RUN.
REQ-017 In RUN, each cycle SHALL replace working bytes cnt*LANES through cnt*LANES+LANES-1 with their S-box images and increment cnt.
REQ-018 cnt SHALL be sized to hold 16/LANES-1.
REQ-019 RUN SHALL last exactly 16/LANES cycles; on the last cycle, cnt wraps to 0 and the FSM enters DONE.
REQ-020 If the input transfer occurs at edge N, out_valid SHALL rise at edge N+16/LANES (N+4 for LANES=4, N+1 for LANES=16).
REQ-021 In DONE, out_valid SHALL be 1 and state_out SHALL equal the working register.
REQ-022 state_out and out_valid SHALL stay stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-023 In DONE with out_ready=1 and in_valid=0, the block SHALL return to IDLE and drop out_valid on the next edge.
REQ-024 In DONE with out_ready=1 and in_valid=1, the output transfer and the new input transfer SHALL occur on the same edge, and the block SHALL go directly to RUN with no IDLE bubble.
REQ-025 The block SHALL have no abort path: in_valid during RUN is ignored and state_in is not sampled.
REQ-026 out_valid SHALL be 0 in IDLE and RUN; state_out SHALL still reflect the working register at all times (it is don't-care to consumers).
REQ-027 Throughput with back-to-back traffic SHALL be one block per 16/LANES+1 cycles.

Reset
REQ-028 While rst_n=0, and immediately on its assertion independent of clk, the block SHALL force: FSM to IDLE, cnt=0, working register=0, out_valid=0, busy=0.
REQ-029 Consequently in_ready SHALL read 1 and state_out SHALL read 0 during reset.
REQ-030 Asserting reset mid-RUN or in DONE SHALL discard the block in progress; no out_valid pulse SHALL follow deassertion.
REQ-031 The first input transfer after reset SHALL be able to occur on the first rising edge after rst_n deasserts.

Verification
REQ-032 Zero state, LANES=4: state_in=0 transferred at edge N -> out_valid rises at edge N+4, state_out=636363...63 (16 bytes), busy high for 4 cycles.
REQ-033 FIPS-197 Appendix B round-1 vector: state_in=193de3bea0f4e22b9ac68d2ae9f84808 -> state_out=d42711aee0bf98f1b8b45de51e415230; checked for LANES=1, 4 and 16, with latencies of 16, 4 and 1 cycles respectively.
REQ-034 Backpressure: hold out_ready=0 for 10 cycles after out_valid -> state_out and out_valid are stable and in_ready=0 throughout; one cycle of out_ready=1 -> exactly one output transfer.
REQ-035 Back-to-back: in_valid held high with out_ready=1, three distinct states -> three correct results, consecutive out_valid rising edges 5 cycles apart (LANES=4), and no IDLE cycle between blocks.
REQ-036 Reset mid-RUN: assert rst_n=0 asynchronously at cnt=2 -> outputs reach reset values before the next edge; after release, no out_valid until a new input transfer.
REQ-037 Exhaustive S-box check: for every byte value b, state_in = 16 copies of b -> state_out = 16 copies of S(b), compared against a FIPS-197 table model.
